bp_update_ctrl: RTL and testbench

BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

---
 rtl/bp_pkg.sv | 20 ++
 rtl/bp_upd_fifo.sv | 33 +++
 rtl/bp_update_ctrl.sv | 85 ++++++++
 tb/tb_bp_update_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: counter constants and the update-queue entry type for the branch-predictor update path.
package bp_pkg;
  localparam int BP_AW = 32;
  typedef struct packed {
    logic [BP_AW-1:0] pc;
    logic             taken;
  } bp_upd_t;
  function automatic int unsigned cnt_min(int unsigned dw);
    return 32'd0 & dw;
  endfunction
  function automatic int unsigned cnt_max(int unsigned dw);
    return (32'd1 << dw) - 32'd1;
  endfunction
  function automatic int unsigned cnt_weak_t(int unsigned dw);
    return 32'd1 << (dw - 32'd1);
  endfunction
  function automatic int unsigned cnt_weak_n(int unsigned dw);
    return (32'd1 << (dw - 32'd1)) - 32'd1;
  endfunction
endpackage

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: power-of-two FIFO holding pending predictor updates; extra pointer bit tells full from empty.
module bp_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      r_wptr, r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  assign o_empty = r_wptr == r_rptr;
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_dout  = r_mem[r_rptr[AW-1:0]];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push && !o_full) r_wptr <= r_wptr + 1'b1;
      if (i_pop && !o_empty) r_rptr <= r_rptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (i_push && !o_full) r_mem[r_wptr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: queues resolved branches and writes updated saturating counters through a 2-stage pipeline.
// Define BP_FWD_EN to forward the in-flight write instead of stalling on a same-PC hazard.
module bp_update_ctrl
  import bp_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [AWIDTH-1:0] upd_pc,
  input  logic              upd_taken,
  output logic [AWIDTH-1:0] bp_ra,
  input  logic [DWIDTH-1:0] bp_dout,
  input  logic              bp_hit,
  output logic [AWIDTH-1:0] bp_wa,
  output logic [DWIDTH-1:0] bp_din,
  output logic              bp_we,
  output logic              idle
);
  localparam logic [DWIDTH-1:0] C_MIN    = DWIDTH'(cnt_min(DWIDTH));
  localparam logic [DWIDTH-1:0] C_MAX    = DWIDTH'(cnt_max(DWIDTH));
  localparam logic [DWIDTH-1:0] C_WEAK_T = DWIDTH'(cnt_weak_t(DWIDTH));
  localparam logic [DWIDTH-1:0] C_WEAK_N = DWIDTH'(cnt_weak_n(DWIDTH));
  logic              w_full, w_empty, w_push, w_pop, w_hazard, w_stall, w_hit;
  logic [AWIDTH:0]   w_head;
  logic [AWIDTH-1:0] w_head_pc;
  logic              w_head_taken;
  logic [DWIDTH-1:0] w_old, w_next;
  logic              r_s2_valid;
  logic [AWIDTH-1:0] r_ra, r_wa;
  logic [DWIDTH-1:0] r_din;
  bp_upd_fifo #(.DEPTH(DEPTH), .WIDTH(AWIDTH + 1)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({upd_pc, upd_taken}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  assign w_head_pc    = w_head[AWIDTH:1];
  assign w_head_taken = w_head[0];
  // the cache read returns pre-write data while S2 still targets the head PC
  assign w_hazard = r_s2_valid && !w_empty && (w_head_pc == r_wa);
`ifdef BP_FWD_EN
  assign w_stall = 1'b0;
  assign w_old   = w_hazard ? r_din : bp_dout;
  assign w_hit   = w_hazard | bp_hit;
`else
  assign w_stall = w_hazard;
  assign w_old   = bp_dout;
  assign w_hit   = bp_hit;
`endif
  assign w_next = !w_hit ? (w_head_taken ? C_WEAK_T : C_WEAK_N)
                : w_head_taken ? (w_old == C_MAX ? C_MAX : w_old + 1'b1)
                : (w_old == C_MIN ? C_MIN : w_old - 1'b1);
  assign w_push    = upd_valid && !w_full;
  assign w_pop     = !w_empty && !w_stall;
  assign upd_ready = !w_full;
  assign bp_ra     = w_empty ? r_ra : w_head_pc;
  assign bp_wa     = r_wa;
  assign bp_din    = r_din;
  assign bp_we     = r_s2_valid;
  assign idle      = w_empty && !r_s2_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_ra       <= '0;
      r_wa       <= '0;
      r_din      <= '0;
    end else begin
      r_s2_valid <= w_pop;
      if (!w_empty) r_ra <= w_head_pc;
      if (w_pop) begin
        r_wa  <= w_head_pc;
        r_din <= w_next;
      end
    end
  end
endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb_bp_update_ctrl: random and directed updates scored against a per-PC counter model and a cache memory model.
module tb_bp_update_ctrl;
  import bp_pkg::*;
  localparam int AW = 32;
  localparam int DW = 2;
  localparam int DEPTH = 4;
`ifdef BP_FWD_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif
  typedef struct {
    bp_upd_t req;
    int      v;
  } exp_t;
  logic          clk = 1'b0, reset = 1'b1, upd_valid = 1'b0, upd_taken = 1'b0;
  logic          upd_ready, bp_hit, bp_we, idle;
  logic [AW-1:0] upd_pc = '0, bp_ra, bp_wa;
  logic [DW-1:0] bp_dout, bp_din;
  bit   [DW-1:0] cache_val [16];
  bit            cache_vld [16];
  int            m_val [16];
  bit            m_vld [16];
  exp_t          exp_q [$];
  exp_t          e_mon;
  int            errors = 0, checks = 0;

  always #5 clk = ~clk;

  bp_update_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .bp_ra(bp_ra), .bp_dout(bp_dout),
    .bp_hit(bp_hit), .bp_wa(bp_wa), .bp_din(bp_din), .bp_we(bp_we), .idle(idle)
  );

  assign bp_dout = cache_val[bp_ra[3:0]];
  assign bp_hit  = cache_vld[bp_ra[3:0]];

  always @(posedge clk) begin
    if (bp_we) begin
      cache_val[bp_wa[3:0]] <= bp_din;
      cache_vld[bp_wa[3:0]] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset && bp_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got wa=%0h din=%0h, expected no write", bp_wa, bp_din);
      end else begin
        e_mon = exp_q.pop_front();
        if (bp_wa !== e_mon.req.pc || int'(bp_din) != e_mon.v) begin
          errors++;
          $display("FAIL write: got wa=%0h din=%0h, expected wa=%0h din=%0h",
                   bp_wa, bp_din, e_mon.req.pc, e_mon.v);
        end
      end
    end
  end

  function automatic int next_cnt(bit hit, int old, bit t);
    int mx = (1 << DW) - 1;
    if (!hit) return t ? (1 << (DW - 1)) : (1 << (DW - 1)) - 1;
    return t ? ((old + 1 > mx) ? mx : old + 1) : ((old - 1 < 0) ? 0 : old - 1);
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask

  task automatic drive(input int pc, input bit t);
    exp_t e;
    upd_valid = 1'b1;
    upd_pc    = AW'(pc);
    upd_taken = t;
    if (upd_ready) begin
      e.req.pc    = AW'(pc);
      e.req.taken = t;
      e.v         = next_cnt(m_vld[pc], m_val[pc], t);
      m_val[pc]   = e.v;
      m_vld[pc]   = 1'b1;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic quiet(input int n);
    upd_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    upd_valid = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) @(negedge clk);
    chk("drain_idle", idle, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    int first, second, n, w;
    repeat (2) @(negedge clk);
    chk("rst_ready", upd_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_we", bp_we, 0);
    chk("rst_ra", bp_ra, 0);
    chk("rst_wa", bp_wa, 0);
    chk("rst_din", bp_din, 0);
    reset = 1'b0;
    drive(7, 1'b1);
    chk("lat_we_early", bp_we, 0);
    quiet(1);
    chk("lat_we", bp_we, 1);
    chk("lat_wa", bp_wa, 7);
    chk("lat_din", bp_din, 2'b10);
    quiet(1);
    chk("lat_idle", idle, 1);
    for (int i = 0; i < 3; i++) drive(3, 1'b1);
    for (int i = 0; i < 3; i++) drive(4, 1'b0);
    wait_idle();
    first = -1;
    second = -1;
    drive(1, 1'b1);
    drive(1, 1'b1);
    upd_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bp_we) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      @(negedge clk);
    end
    chk("b2b_first", 64'(first), 0);
    chk("b2b_gap", 64'(second - first), 64'(GAP));
    wait_idle();
`ifndef BP_FWD_EN
    n = 0;
    while (upd_ready && n < 40) begin
      drive(5, 1'($urandom_range(0, 1)));
      n++;
    end
    chk("full_occupancy", exp_q.size(), DEPTH);
    drive(9, 1'b1);
    upd_valid = 1'b0;
    w = 0;
    for (int i = 0; i < 40 && !idle; i++) begin
      if (bp_we) w++;
      @(negedge clk);
    end
    chk("drain_writes", 64'(w), DEPTH);
    wait_idle();
    n = 0;
    #1;
    while (!(bp_we && exp_q.size() >= 3) && n < 40) begin
      drive(6, 1'($urandom_range(0, 1)));
      #1;
      n++;
    end
    chk("pre_reset_queued", exp_q.size(), 3);
    reset = 1'b1;
    upd_valid = 1'b0;
    #1;
    chk("mid_rst_we", bp_we, 0);
    chk("mid_rst_idle", idle, 1);
    chk("mid_rst_ready", upd_ready, 1);
    chk("mid_rst_ra", bp_ra, 0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      m_val[i] = int'(cache_val[i]);
      m_vld[i] = cache_vld[i];
    end
    @(negedge clk);
    reset = 1'b0;
    w = 0;
    for (int i = 0; i < 6; i++) begin
      if (bp_we) w++;
      @(negedge clk);
    end
    chk("post_reset_writes", 64'(w), 0);
`endif
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) drive(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      else quiet(1);
    end
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
